rename_ckpt_unit: RTL and testbench

// Parametrised register-renaming unit for the Tomasulo dispatch stage: tag free list, register status table, branch checkpoints.

---
 rtl/rename_pkg.sv | 47 ++++
 rtl/tag_free_list.sv | 41 ++++
 rtl/rename_ckpt_unit.sv | 126 ++++++++++++
 tb/tb_rename_ckpt_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared sizes, rename table entry and checkpoint types
package rename_pkg;

  localparam int NUM_REGS = 32;
  localparam int NUM_TAGS = 64;
  localparam int NUM_CKPT = 4;

  function automatic int tag_width(input int num_tags);
    return $clog2(num_tags);
  endfunction

  function automatic int reg_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  localparam int TAG_W  = tag_width(NUM_TAGS);
  localparam int REG_W  = reg_width(NUM_REGS);
  localparam int CKPT_W = $clog2(NUM_CKPT);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } rst_entry_t;

  typedef struct packed {
    rst_entry_t [NUM_REGS-1:0] map;
    logic [TAG_W:0]            rptr;
  } ckpt_t;

  // A broadcast tag makes a pending mapping ready; other entries are untouched.
  function automatic rst_entry_t cdb_clear(input rst_entry_t e, input logic v,
                                           input logic [TAG_W-1:0] t);
    rst_entry_t r;
    r = e;
    if (v && e.valid && (e.tag == t)) r.valid = 1'b0;
    return r;
  endfunction

  function automatic ckpt_t ckpt_clear(input ckpt_t c, input logic v,
                                       input logic [TAG_W-1:0] t);
    ckpt_t r;
    r = c;
    for (int i = 0; i < NUM_REGS; i++) r.map[i] = cdb_clear(c.map[i], v, t);
    return r;
  endfunction

endpackage

// File: rtl/tag_free_list.sv
// rtl/tag_free_list.sv - circular free list of physical tags with rptr restore
module tag_free_list
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pop,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             restore,
  input  logic [TAG_W:0]   restore_rptr,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W:0]   rptr,
  output logic [TAG_W:0]   free_count
);

  localparam logic [TAG_W:0] FULL_PTR = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0] mem [NUM_TAGS];
  logic [TAG_W:0]   wptr;

  assign head_tag   = mem[rptr[TAG_W-1:0]];
  assign free_count = wptr - rptr;

  // Returned tags land at wptr; a restore rewinds rptr so wrong-path tags are free again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= TAG_W'(i);
      rptr <= '0;
      wptr <= FULL_PTR;
    end else begin
      if (push) begin
        mem[wptr[TAG_W-1:0]] <= push_tag;
        wptr                 <= wptr + 1'b1;
      end
      if (restore)  rptr <= restore_rptr;
      else if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/rename_ckpt_unit.sv
// rtl/rename_ckpt_unit.sv - register rename unit with branch checkpoints and CDB tag release
module rename_ckpt_unit
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs1_tag_valid,
  output logic             rs2_tag_valid,
  input  logic [REG_W-1:0] rd,
  input  logic             alloc_req,
  output logic             alloc_ok,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             ckpt_take,
  output logic             ckpt_ok,
  output logic             ckpt_full,
  input  logic             br_resolve,
  input  logic             br_mispredict,
  output logic [TAG_W:0]   free_count
);

  localparam logic [CKPT_W:0] CKPT_DEPTH = (CKPT_W+1)'(NUM_CKPT);

  rst_entry_t status     [NUM_REGS];
  rst_entry_t status_upd [NUM_REGS];
  ckpt_t      ckpt_mem   [NUM_CKPT];
  ckpt_t      snap_new;
  ckpt_t      head_clr;

  logic [CKPT_W:0]   ckpt_head;
  logic [CKPT_W:0]   ckpt_tail;
  logic [CKPT_W:0]   ckpt_count;
  logic [CKPT_W-1:0] head_idx;
  logic [CKPT_W-1:0] tail_idx;
  logic              ckpt_empty;
  logic              mispredict_in;
  logic              do_mis;
  logic              do_pop;
  logic              do_push;
  logic [TAG_W:0]    fl_rptr;

  assign ckpt_count = ckpt_tail - ckpt_head;
  assign head_idx   = ckpt_head[CKPT_W-1:0];
  assign tail_idx   = ckpt_tail[CKPT_W-1:0];
  assign ckpt_empty = (ckpt_count == '0);
  assign ckpt_full  = (ckpt_count == CKPT_DEPTH);

  assign mispredict_in = br_resolve & br_mispredict;
  assign do_mis        = mispredict_in & ~ckpt_empty;
  assign do_pop        = br_resolve & ~br_mispredict & ~ckpt_empty;
  assign do_push       = ckpt_take & ~ckpt_full & ~do_mis;
  assign ckpt_ok       = do_push;

  assign alloc_ok = alloc_req & (rd != '0) & (free_count != '0) & ~mispredict_in;

  assign rs1_tag       = status[rs1].tag;
  assign rs1_tag_valid = status[rs1].valid;
  assign rs2_tag       = status[rs2].tag;
  assign rs2_tag_valid = status[rs2].valid;

  tag_free_list u_free_list (
    .clk          (clk),
    .rst          (rst),
    .pop          (alloc_ok),
    .push         (cdb_valid),
    .push_tag     (cdb_tag),
    .restore      (do_mis),
    .restore_rptr (ckpt_mem[head_idx].rptr),
    .head_tag     (rd_tag),
    .rptr         (fl_rptr),
    .free_count   (free_count)
  );

  // Next table state: CDB clear first, then a same-cycle rename overrides it.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      status_upd[r] = cdb_clear(status[r], cdb_valid, cdb_tag);
      if (alloc_ok && (rd == REG_W'(r))) begin
        status_upd[r].valid = 1'b1;
        status_upd[r].tag   = rd_tag;
      end
    end
  end

  // Snapshot for a new checkpoint and the restore image of the oldest one.
  always_comb begin
    snap_new = '0;
    for (int r = 0; r < NUM_REGS; r++) snap_new.map[r] = status_upd[r];
    snap_new.rptr = fl_rptr + (TAG_W+1)'(alloc_ok);
    head_clr = ckpt_clear(ckpt_mem[head_idx], cdb_valid, cdb_tag);
  end

  // Status table: normal update, or wholesale restore from the oldest checkpoint.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst)         status[r] <= '0;
      else if (do_mis) status[r] <= head_clr.map[r];
      else             status[r] <= status_upd[r];
    end
  end

  // Checkpoint FIFO: snapshots keep seeing CDB clears so a restore is never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_CKPT; s++) ckpt_mem[s] <= '0;
      ckpt_head <= '0;
      ckpt_tail <= '0;
    end else begin
      for (int s = 0; s < NUM_CKPT; s++)
        ckpt_mem[s] <= ckpt_clear(ckpt_mem[s], cdb_valid, cdb_tag);
      if (do_push) ckpt_mem[tail_idx] <= snap_new;
      if (do_mis) begin
        ckpt_tail <= ckpt_head;
      end else begin
        if (do_push) ckpt_tail <= ckpt_tail + 1'b1;
        if (do_pop)  ckpt_head <= ckpt_head + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rename_ckpt_unit.sv
// tb/tb_rename_ckpt_unit.sv - scoreboard bench for rename_ckpt_unit
module tb_rename_ckpt_unit;
  import rename_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [TAG_W-1:0] rs1_tag, rs2_tag, rd_tag;
  logic             rs1_tag_valid, rs2_tag_valid;
  logic             alloc_req = 1'b0, alloc_ok;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic             ckpt_take = 1'b0, ckpt_ok, ckpt_full;
  logic             br_resolve = 1'b0, br_mispredict = 1'b0;
  logic [TAG_W:0]   free_count;

  always #5 clk = ~clk;

  rename_ckpt_unit dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_tag_valid(rs1_tag_valid), .rs2_tag_valid(rs2_tag_valid),
    .rd(rd), .alloc_req(alloc_req), .alloc_ok(alloc_ok), .rd_tag(rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .ckpt_take(ckpt_take), .ckpt_ok(ckpt_ok), .ckpt_full(ckpt_full),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict),
    .free_count(free_count)
  );

  typedef enum int {S_RS1_TAG, S_RS1_V, S_RS2_TAG, S_RS2_V, S_ALLOC_OK,
                    S_RD_TAG, S_CKPT_OK, S_CKPT_FULL, S_FREE_CNT} sel_t;
  typedef struct {
    string name;
    sel_t  sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic int observe(input sel_t s);
    case (s)
      S_RS1_TAG:   return int'(rs1_tag);
      S_RS1_V:     return int'(rs1_tag_valid);
      S_RS2_TAG:   return int'(rs2_tag);
      S_RS2_V:     return int'(rs2_tag_valid);
      S_ALLOC_OK:  return int'(alloc_ok);
      S_RD_TAG:    return int'(rd_tag);
      S_CKPT_OK:   return int'(ckpt_ok);
      S_CKPT_FULL: return int'(ckpt_full);
      default:     return int'(free_count);
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      int   act;
      e   = exp_q.pop_front();
      act = observe(e.sel);
      n_cmp++;
      if (act != e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
      end
    end
  end

  task automatic exp(input string name, input sel_t s, input int v);
    exp_t e;
    e.name = name;
    e.sel  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; alloc_req = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; ckpt_take = 1'b0;
    br_resolve = 1'b0; br_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic alloc(input int r, input int tag);
    alloc_req = 1'b1;
    rd        = REG_W'(r);
    exp("alloc_ok", S_ALLOC_OK, 1);
    exp("rd_tag", S_RD_TAG, tag);
  endtask

  task automatic src1(input string name, input int r, input int tag, input int v);
    rs1 = REG_W'(r);
    exp({name, "_tag1"}, S_RS1_TAG, tag);
    exp({name, "_v1"}, S_RS1_V, v);
  endtask

  task automatic src2(input string name, input int r, input int tag, input int v);
    rs2 = REG_W'(r);
    exp({name, "_tag2"}, S_RS2_TAG, tag);
    exp({name, "_v2"}, S_RS2_V, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    exp("rst_free", S_FREE_CNT, 64);
    exp("rst_rd_tag", S_RD_TAG, 0);
    exp("rst_full", S_CKPT_FULL, 0);
    exp("rst_alloc_ok", S_ALLOC_OK, 0);
    exp("rst_ckpt_ok", S_CKPT_OK, 0);
    src1("rst", 5, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (free_count != 7'd64) begin
      n_fail++;
      $display("FAIL rst_free_direct: got %0d expected 64", free_count);
    end
    n_cmp++;
    if (rd_tag != 6'd0) begin
      n_fail++;
      $display("FAIL rst_rd_tag_direct: got %0d expected 0", rd_tag);
    end
    n_cmp++;
    if (ckpt_full != 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_direct: got %0d expected 0", ckpt_full);
    end

    for (int i = 0; i < 64; i++) begin
      cyc();
      alloc(1 + (i % 31), i);
      exp("drain_free", S_FREE_CNT, 64 - i);
    end
    cyc();
    alloc_req = 1'b1; rd = 5'd1; cdb_valid = 1'b1; cdb_tag = 6'd7;
    exp("empty_alloc_ok", S_ALLOC_OK, 0);
    exp("empty_free", S_FREE_CNT, 0);
    src1("reg8_remapped", 8, 38, 1);
    cyc();
    alloc(2, 7);
    exp("returned_free", S_FREE_CNT, 1);
    src1("reg8_kept", 8, 38, 1);

    do_reset();
    alloc(5, 0);
    cyc();
    src1("r5", 5, 0, 1);
    src2("r5", 5, 0, 1);
    exp("r5_free", S_FREE_CNT, 63);
    cyc();
    cdb_valid = 1'b1; cdb_tag = 6'd0;
    src1("r5_precdb", 5, 0, 1);
    cyc();
    src1("r5_cleared", 5, 0, 0);
    exp("r5_free_back", S_FREE_CNT, 64);

    do_reset();
    alloc(3, 0);
    cyc();
    alloc(3, 1);
    src1("r3_old", 3, 0, 1);
    cyc();
    cdb_valid = 1'b1; cdb_tag = 6'd0;
    src1("r3_new", 3, 1, 1);
    cyc();
    src1("r3_stale_cdb", 3, 1, 1);
    alloc(3, 2);
    cdb_valid = 1'b1; cdb_tag = 6'd1;
    cyc();
    src1("r3_rename_wins", 3, 2, 1);
    exp("r3_free", S_FREE_CNT, 63);

    do_reset();
    ckpt_take = 1'b1;
    exp("mp_ckpt_ok", S_CKPT_OK, 1);
    cyc(); alloc(4, 0);
    cyc(); alloc(6, 1);
    cyc(); alloc(4, 2);
    src1("mp_wrongpath", 4, 0, 1);
    cyc();
    br_resolve = 1'b1; br_mispredict = 1'b1; alloc_req = 1'b1; rd = 5'd9;
    exp("mp_alloc_blocked", S_ALLOC_OK, 0);
    exp("mp_free_before", S_FREE_CNT, 61);
    cyc();
    exp("mp_free_after", S_FREE_CNT, 64);
    exp("mp_rd_tag", S_RD_TAG, 0);
    exp("mp_full", S_CKPT_FULL, 0);
    src1("mp_r4", 4, 0, 0);
    src2("mp_r6", 6, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (free_count != 7'd64) begin
      n_fail++;
      $display("FAIL mp_free_direct: got %0d expected 64", free_count);
    end
    n_cmp++;
    if (rs1_tag_valid != 1'b0) begin
      n_fail++;
      $display("FAIL mp_r4_valid_direct: got %0d expected 0", rs1_tag_valid);
    end

    do_reset();
    alloc(12, 0);
    cyc();
    ckpt_take = 1'b1;
    exp("ck1_ok", S_CKPT_OK, 1);
    cyc();
    ckpt_take = 1'b1;
    exp("ck2_ok", S_CKPT_OK, 1);
    alloc(13, 1);
    cyc();
    ckpt_take = 1'b1;
    exp("ck3_ok", S_CKPT_OK, 1);
    cyc();
    ckpt_take = 1'b1;
    exp("ck4_ok", S_CKPT_OK, 1);
    exp("ck4_not_full", S_CKPT_FULL, 0);
    cyc();
    ckpt_take = 1'b1;
    exp("ck_full", S_CKPT_FULL, 1);
    exp("ck5_rejected", S_CKPT_OK, 0);
    cyc();
    br_resolve = 1'b1;
    exp("ck_full_pre_resolve", S_CKPT_FULL, 1);
    cyc();
    exp("ck_full_after_resolve", S_CKPT_FULL, 0);
    cdb_valid = 1'b1; cdb_tag = 6'd0;
    alloc(14, 2);
    cyc();
    br_resolve = 1'b1; br_mispredict = 1'b1;
    cyc();
    src1("ck2_r12", 12, 0, 0);
    src2("ck2_r13", 13, 1, 1);
    exp("ck2_free", S_FREE_CNT, 63);
    exp("ck2_rd_tag", S_RD_TAG, 2);
    exp("ck2_full", S_CKPT_FULL, 0);
    ckpt_take = 1'b1;
    exp("flush_ckpt_ok", S_CKPT_OK, 1);
    cyc();
    src1("ck2_r14", 14, 0, 0);
    ckpt_take = 1'b1; br_resolve = 1'b1;
    exp("take_and_resolve_ok", S_CKPT_OK, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      ckpt_take = 1'b1;
      exp("refill_ok", S_CKPT_OK, 1);
      exp("refill_not_full", S_CKPT_FULL, 0);
    end
    cyc();
    exp("refill_full", S_CKPT_FULL, 1);

    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
